register_rename: RTL and testbench

- Two-wide rename stage sitting directly upstream of the reorder buffer.
- Maps architectural source and destination registers of up to two decoded instructions per cycle onto physical registers, using a register alias table (RAT) and a FIFO free list.
- Produces dest / old_dest / source tags consumed by ROB reservation.
- Recycles physical registers returned by ROB commit.

---
 rtl/register_rename.sv | 184 ++++++++++++++++++
 tb/tb_register_rename.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/register_rename.sv
// rtl/register_rename.sv - two-wide register rename stage with RAT and FIFO free list
// Maps architectural regs of up to two instructions per cycle onto physical regs; recycles committed regs.
module register_rename #(
  parameter int NUM_A_REGS = 32,
  parameter int NUM_P_REGS = 64,
  localparam int A = $clog2(NUM_A_REGS),
  localparam int P = $clog2(NUM_P_REGS)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_rename_instr0_i,
  input  logic         en_rename_instr1_i,
  input  logic [A-1:0] instr0_rs1_i,
  input  logic [A-1:0] instr0_rs2_i,
  input  logic [A-1:0] instr0_rd_i,
  input  logic         instr0_wr_i,
  input  logic [A-1:0] instr1_rs1_i,
  input  logic [A-1:0] instr1_rs2_i,
  input  logic [A-1:0] instr1_rd_i,
  input  logic         instr1_wr_i,
  output logic [P-1:0] instr0_ps1_o,
  output logic [P-1:0] instr0_ps2_o,
  output logic [P-1:0] instr0_pd_o,
  output logic [P-1:0] instr0_old_pd_o,
  output logic         instr0_valid_o,
  output logic [P-1:0] instr1_ps1_o,
  output logic [P-1:0] instr1_ps2_o,
  output logic [P-1:0] instr1_pd_o,
  output logic [P-1:0] instr1_old_pd_o,
  output logic         instr1_valid_o,
  input  logic         en_free0_i,
  input  logic         en_free1_i,
  input  logic [P-1:0] free_preg0_i,
  input  logic [P-1:0] free_preg1_i,
  output logic         stall_o
);

  localparam logic [P:0]   NUM_P_W    = (P+1)'(NUM_P_REGS);
  localparam logic [P:0]   INIT_COUNT = (P+1)'(NUM_P_REGS - NUM_A_REGS);
  localparam logic [P-1:0] INIT_TAIL  = P'(NUM_A_REGS % NUM_P_REGS);

  logic [P-1:0] rat_q [NUM_A_REGS];
  logic [P-1:0] rat_d [NUM_A_REGS];
  logic [P-1:0] fl_q  [NUM_P_REGS];
  logic [P-1:0] fl_d  [NUM_P_REGS];
  logic [P-1:0] head_q, head_d;
  logic [P-1:0] tail_q, tail_d;
  logic [P:0]   count_q, count_d;

  logic         instr0_valid_q, instr0_valid_d;
  logic [P-1:0] instr0_ps1_q, instr0_ps1_d;
  logic [P-1:0] instr0_ps2_q, instr0_ps2_d;
  logic [P-1:0] instr0_pd_q, instr0_pd_d;
  logic [P-1:0] instr0_old_pd_q, instr0_old_pd_d;
  logic         instr1_valid_q, instr1_valid_d;
  logic [P-1:0] instr1_ps1_q, instr1_ps1_d;
  logic [P-1:0] instr1_ps2_q, instr1_ps2_d;
  logic [P-1:0] instr1_pd_q, instr1_pd_d;
  logic [P-1:0] instr1_old_pd_q, instr1_old_pd_d;

  logic         alloc0, alloc1, stall;
  logic         go0, go1, push0, push1;
  logic [P:0]   need, pops, avail;
  logic [P-1:0] head_p1, pd0, pd1;
  logic [P-1:0] map0_rs1, map0_rs2, map1_rs1, map1_rs2;

  function automatic logic [P-1:0] ptr_inc(input logic [P-1:0] ptr);
    logic [P:0] sum;
    sum = {1'b0, ptr} + 1'b1;
    if (sum >= NUM_P_W) ptr_inc = '0;
    else                ptr_inc = sum[P-1:0];
  endfunction

  always_comb begin
    alloc0  = en_rename_instr0_i && instr0_wr_i && (instr0_rd_i != '0);
    alloc1  = en_rename_instr1_i && instr1_wr_i && (instr1_rd_i != '0);
    need    = (P+1)'(alloc0) + (P+1)'(alloc1);
    // Only the registered count is consulted; same-cycle frees help next cycle.
    stall   = need > count_q;
    go0     = en_rename_instr0_i && !stall;
    go1     = en_rename_instr1_i && !stall;
    pops    = stall ? '0 : need;

    head_p1 = ptr_inc(head_q);
    pd0     = alloc0 ? fl_q[head_q] : '0;
    pd1     = alloc1 ? fl_q[alloc0 ? head_p1 : head_q] : '0;

    map0_rs1 = (instr0_rs1_i == '0) ? '0 : rat_q[instr0_rs1_i];
    map0_rs2 = (instr0_rs2_i == '0) ? '0 : rat_q[instr0_rs2_i];
    map1_rs1 = (alloc0 && instr1_rs1_i == instr0_rd_i) ? pd0 :
               (instr1_rs1_i == '0) ? '0 : rat_q[instr1_rs1_i];
    map1_rs2 = (alloc0 && instr1_rs2_i == instr0_rd_i) ? pd0 :
               (instr1_rs2_i == '0) ? '0 : rat_q[instr1_rs2_i];

    instr0_valid_d  = go0;
    instr0_ps1_d    = go0 ? map0_rs1 : '0;
    instr0_ps2_d    = go0 ? map0_rs2 : '0;
    instr0_pd_d     = go0 ? pd0 : '0;
    instr0_old_pd_d = (go0 && alloc0) ? rat_q[instr0_rd_i] : '0;
    instr1_valid_d  = go1;
    instr1_ps1_d    = go1 ? map1_rs1 : '0;
    instr1_ps2_d    = go1 ? map1_rs2 : '0;
    instr1_pd_d     = go1 ? pd1 : '0;
    instr1_old_pd_d = '0;
    if (go1 && alloc1) begin
      instr1_old_pd_d = (alloc0 && instr1_rd_i == instr0_rd_i) ? pd0 : rat_q[instr1_rd_i];
    end

    rat_d = rat_q;
    if (!stall && alloc0) rat_d[instr0_rd_i] = pd0;
    if (!stall && alloc1) rat_d[instr1_rd_i] = pd1;

    head_d = head_q;
    if (!stall && alloc0) head_d = ptr_inc(head_d);
    if (!stall && alloc1) head_d = ptr_inc(head_d);

    // Pops are taken first so a full list being drained can still accept returns.
    avail  = count_q - pops;
    fl_d   = fl_q;
    tail_d = tail_q;
    push0  = en_free0_i && (free_preg0_i != '0) && (avail < NUM_P_W);
    if (push0) begin
      fl_d[tail_d] = free_preg0_i;
      tail_d       = ptr_inc(tail_d);
    end
    push1  = en_free1_i && (free_preg1_i != '0) && ((avail + (P+1)'(push0)) < NUM_P_W);
    if (push1) begin
      fl_d[tail_d] = free_preg1_i;
      tail_d       = ptr_inc(tail_d);
    end
    count_d = avail + (P+1)'(push0) + (P+1)'(push1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_A_REGS; i++) rat_q[i] <= P'(i);
      for (int i = 0; i < NUM_P_REGS; i++) begin
        fl_q[i] <= (i < NUM_P_REGS - NUM_A_REGS) ? P'(NUM_A_REGS + i) : '0;
      end
      head_q          <= '0;
      tail_q          <= INIT_TAIL;
      count_q         <= INIT_COUNT;
      instr0_valid_q  <= 1'b0;
      instr0_ps1_q    <= '0;
      instr0_ps2_q    <= '0;
      instr0_pd_q     <= '0;
      instr0_old_pd_q <= '0;
      instr1_valid_q  <= 1'b0;
      instr1_ps1_q    <= '0;
      instr1_ps2_q    <= '0;
      instr1_pd_q     <= '0;
      instr1_old_pd_q <= '0;
    end else begin
      rat_q           <= rat_d;
      fl_q            <= fl_d;
      head_q          <= head_d;
      tail_q          <= tail_d;
      count_q         <= count_d;
      instr0_valid_q  <= instr0_valid_d;
      instr0_ps1_q    <= instr0_ps1_d;
      instr0_ps2_q    <= instr0_ps2_d;
      instr0_pd_q     <= instr0_pd_d;
      instr0_old_pd_q <= instr0_old_pd_d;
      instr1_valid_q  <= instr1_valid_d;
      instr1_ps1_q    <= instr1_ps1_d;
      instr1_ps2_q    <= instr1_ps2_d;
      instr1_pd_q     <= instr1_pd_d;
      instr1_old_pd_q <= instr1_old_pd_d;
    end
  end

  assign stall_o         = stall;
  assign instr0_valid_o  = instr0_valid_q;
  assign instr0_ps1_o    = instr0_ps1_q;
  assign instr0_ps2_o    = instr0_ps2_q;
  assign instr0_pd_o     = instr0_pd_q;
  assign instr0_old_pd_o = instr0_old_pd_q;
  assign instr1_valid_o  = instr1_valid_q;
  assign instr1_ps1_o    = instr1_ps1_q;
  assign instr1_ps2_o    = instr1_ps2_q;
  assign instr1_pd_o     = instr1_pd_q;
  assign instr1_old_pd_o = instr1_old_pd_q;

endmodule

// File: tb/tb_register_rename.sv
// tb/tb_register_rename.sv - scoreboard bench for the two-wide register rename stage
module tb_register_rename;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       en_rename_instr0_i, en_rename_instr1_i;
  logic [4:0] instr0_rs1_i, instr0_rs2_i, instr0_rd_i;
  logic [4:0] instr1_rs1_i, instr1_rs2_i, instr1_rd_i;
  logic       instr0_wr_i, instr1_wr_i;
  logic [5:0] instr0_ps1_o, instr0_ps2_o, instr0_pd_o, instr0_old_pd_o;
  logic [5:0] instr1_ps1_o, instr1_ps2_o, instr1_pd_o, instr1_old_pd_o;
  logic       instr0_valid_o, instr1_valid_o;
  logic       en_free0_i, en_free1_i;
  logic [5:0] free_preg0_i, free_preg1_i;
  logic       stall_o;

  typedef struct {
    int v0, ps1_0, ps2_0, pd0, old0;
    int v1, ps1_1, ps2_1, pd1, old1;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;

  register_rename dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .en_rename_instr0_i(en_rename_instr0_i), .en_rename_instr1_i(en_rename_instr1_i),
    .instr0_rs1_i(instr0_rs1_i), .instr0_rs2_i(instr0_rs2_i),
    .instr0_rd_i(instr0_rd_i), .instr0_wr_i(instr0_wr_i),
    .instr1_rs1_i(instr1_rs1_i), .instr1_rs2_i(instr1_rs2_i),
    .instr1_rd_i(instr1_rd_i), .instr1_wr_i(instr1_wr_i),
    .instr0_ps1_o(instr0_ps1_o), .instr0_ps2_o(instr0_ps2_o),
    .instr0_pd_o(instr0_pd_o), .instr0_old_pd_o(instr0_old_pd_o),
    .instr0_valid_o(instr0_valid_o),
    .instr1_ps1_o(instr1_ps1_o), .instr1_ps2_o(instr1_ps2_o),
    .instr1_pd_o(instr1_pd_o), .instr1_old_pd_o(instr1_old_pd_o),
    .instr1_valid_o(instr1_valid_o),
    .en_free0_i(en_free0_i), .en_free1_i(en_free1_i),
    .free_preg0_i(free_preg0_i), .free_preg1_i(free_preg1_i),
    .stall_o(stall_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    if (obs != expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic exp_t zero_exp();
    exp_t e;
    e = '{default: 0};
    return e;
  endfunction

  task automatic clear_inputs();
    en_rename_instr0_i = 0; en_rename_instr1_i = 0;
    instr0_rs1_i = 0; instr0_rs2_i = 0; instr0_rd_i = 0; instr0_wr_i = 0;
    instr1_rs1_i = 0; instr1_rs2_i = 0; instr1_rd_i = 0; instr1_wr_i = 0;
    en_free0_i = 0; en_free1_i = 0; free_preg0_i = 0; free_preg1_i = 0;
  endtask

  task automatic slot0(input int rd, input int rs1, input int rs2, input int wr);
    en_rename_instr0_i = 1'b1;
    instr0_rd_i = 5'(rd); instr0_rs1_i = 5'(rs1); instr0_rs2_i = 5'(rs2); instr0_wr_i = 1'(wr);
  endtask

  task automatic slot1(input int rd, input int rs1, input int rs2, input int wr);
    en_rename_instr1_i = 1'b1;
    instr1_rd_i = 5'(rd); instr1_rs1_i = 5'(rs1); instr1_rs2_i = 5'(rs2); instr1_wr_i = 1'(wr);
  endtask

  task automatic free0(input int p);
    en_free0_i = 1'b1; free_preg0_i = 6'(p);
  endtask

  task automatic free1(input int p);
    en_free1_i = 1'b1; free_preg1_i = 6'(p);
  endtask

  task automatic chk_stall(input string tag, input int expv);
    #1;
    chk({tag, ".stall"}, int'(stall_o), expv);
  endtask

  // Expected result is queued as stimulus is applied and popped once the registered output appears.
  task automatic step(input string tag, input exp_t e);
    exp_t got;
    sb_q.push_back(e);
    @(posedge clk_i);
    #1;
    got = sb_q.pop_front();
    chk({tag, ".v0"},    int'(instr0_valid_o),  got.v0);
    chk({tag, ".ps1_0"}, int'(instr0_ps1_o),    got.ps1_0);
    chk({tag, ".ps2_0"}, int'(instr0_ps2_o),    got.ps2_0);
    chk({tag, ".pd0"},   int'(instr0_pd_o),     got.pd0);
    chk({tag, ".old0"},  int'(instr0_old_pd_o), got.old0);
    chk({tag, ".v1"},    int'(instr1_valid_o),  got.v1);
    chk({tag, ".ps1_1"}, int'(instr1_ps1_o),    got.ps1_1);
    chk({tag, ".ps2_1"}, int'(instr1_ps2_o),    got.ps2_1);
    chk({tag, ".pd1"},   int'(instr1_pd_o),     got.pd1);
    chk({tag, ".old1"},  int'(instr1_old_pd_o), got.old1);
    @(negedge clk_i);
    clear_inputs();
  endtask

  task automatic do_reset(input string tag);
    rst_i = 1'b1;
    step(tag, zero_exp());
    rst_i = 1'b0;
  endtask

  initial begin
    exp_t e;
    int   prev20, prev21, f0;
    clear_inputs();
    @(negedge clk_i);
    do_reset("reset");
    chk_stall("idle", 0);

    slot0(5, 1, 2, 1);
    chk_stall("t1", 0);
    e = zero_exp(); e.v0 = 1; e.pd0 = 32; e.old0 = 5; e.ps1_0 = 1; e.ps2_0 = 2;
    step("t1", e);

    do_reset("reset_dual");
    slot0(3, 0, 0, 1); slot1(3, 3, 4, 1);
    e = zero_exp(); e.v0 = 1; e.pd0 = 32; e.old0 = 3;
    e.v1 = 1; e.ps1_1 = 32; e.ps2_1 = 4; e.pd1 = 33; e.old1 = 32;
    step("dual", e);
    slot0(0, 3, 0, 0); slot1(0, 5, 3, 0);
    e = zero_exp(); e.v0 = 1; e.ps1_0 = 33; e.v1 = 1; e.ps1_1 = 5; e.ps2_1 = 33;
    step("read_x3", e);
    slot0(7, 0, 0, 1);
    e = zero_exp(); e.v0 = 1; e.pd0 = 34; e.old0 = 7;
    step("after_dual", e);

    do_reset("reset_x0");
    slot0(0, 0, 7, 1);
    e = zero_exp(); e.v0 = 1; e.ps2_0 = 7;
    step("x0", e);
    slot0(6, 0, 0, 1);
    e = zero_exp(); e.v0 = 1; e.pd0 = 32; e.old0 = 6;
    step("after_x0", e);

    do_reset("reset_stall");
    for (int k = 0; k < 15; k++) begin
      slot0(10, 0, 0, 1); slot1(11, 0, 0, 1);
      e = zero_exp();
      e.v0 = 1; e.pd0 = 32 + 2*k; e.old0 = (k == 0) ? 10 : 30 + 2*k;
      e.v1 = 1; e.pd1 = 33 + 2*k; e.old1 = (k == 0) ? 11 : 31 + 2*k;
      step("fill", e);
    end
    slot0(12, 10, 11, 1);
    e = zero_exp(); e.v0 = 1; e.pd0 = 62; e.old0 = 12; e.ps1_0 = 60; e.ps2_0 = 61;
    step("fill_last", e);
    slot0(13, 0, 0, 1); slot1(14, 0, 0, 1); free0(7);
    chk_stall("stall_two", 1);
    step("stall_two", zero_exp());
    slot0(13, 0, 0, 1); slot1(14, 13, 0, 1);
    chk_stall("unstall", 0);
    e = zero_exp(); e.v0 = 1; e.pd0 = 63; e.old0 = 13;
    e.v1 = 1; e.ps1_1 = 63; e.pd1 = 7; e.old1 = 14;
    step("unstall", e);
    slot0(15, 0, 0, 1);
    chk_stall("empty_one", 1);
    step("empty_one", zero_exp());
    slot0(0, 14, 0, 0);
    chk_stall("empty_nowr", 0);
    e = zero_exp(); e.v0 = 1; e.ps1_0 = 7;
    step("empty_nowr", e);

    do_reset("reset_wrap");
    for (int k = 0; k < 16; k++) begin
      slot0(20, 0, 0, 1); slot1(21, 0, 0, 1);
      e = zero_exp();
      e.v0 = 1; e.pd0 = 32 + 2*k; e.old0 = (k == 0) ? 20 : 30 + 2*k;
      e.v1 = 1; e.pd1 = 33 + 2*k; e.old1 = (k == 0) ? 21 : 31 + 2*k;
      step("wfill", e);
    end
    prev20 = 62; prev21 = 63;
    for (int j = 0; j < 17; j++) begin
      f0 = 40 - 2*j;
      free0(f0); free1(f0 + 1);
      step("wrap_free", zero_exp());
      slot0(20, 0, 0, 1); slot1(21, 20, 0, 1);
      chk_stall("wrap_alloc", 0);
      e = zero_exp();
      e.v0 = 1; e.pd0 = f0; e.old0 = prev20;
      e.v1 = 1; e.ps1_1 = f0; e.pd1 = f0 + 1; e.old1 = prev21;
      step("wrap_alloc", e);
      prev20 = f0; prev21 = f0 + 1;
    end
    slot0(22, 0, 0, 1);
    chk_stall("wrap_empty", 1);
    step("wrap_empty", zero_exp());
    free0(0); free1(9);
    step("free_p0", zero_exp());
    slot0(22, 0, 0, 1); slot1(23, 0, 0, 1);
    chk_stall("p0_ignored", 1);
    step("p0_ignored", zero_exp());
    slot0(22, 0, 0, 1);
    chk_stall("p9_alloc", 0);
    e = zero_exp(); e.v0 = 1; e.pd0 = 9; e.old0 = 22;
    step("p9_alloc", e);

    slot0(5, 1, 2, 1); slot1(6, 5, 0, 1);
    do_reset("reset_mid");
    slot0(5, 20, 21, 1); slot1(6, 5, 0, 1);
    e = zero_exp(); e.v0 = 1; e.pd0 = 32; e.old0 = 5; e.ps1_0 = 20; e.ps2_0 = 21;
    e.v1 = 1; e.ps1_1 = 32; e.pd1 = 33; e.old1 = 6;
    step("post_reset", e);

    chk("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
